// File: rtl/logmap_pkg.sv
// logmap_pkg: shared state, error codes and register-map constants for the logmapAXI
// configuration sequencer.
package logmap_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_FINISH
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_BRESP     = 2'd1;
    localparam logic [1:0] ERR_RRESP     = 2'd2;
    localparam logic [1:0] ERR_DATA      = 2'd3;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam int         NUM_REGS      = 4;
    localparam int         REG_STRIDE    = 4;
endpackage

// File: rtl/logmap_watchdog.sv
// logmap_watchdog: per-state wait counter; o_expired rises on the C_TIMEOUT-th cycle
// since the last clear and holds until cleared again.
module logmap_watchdog #(
    parameter int C_TIMEOUT = 256
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_expired
);
    localparam int             W    = $clog2(C_TIMEOUT + 1);
    localparam logic [W-1:0]   LAST = W'(C_TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else
            r_cnt <= i_clear ? '0 : (o_expired ? r_cnt : r_cnt + 1'b1);
    end

    assign o_expired = r_cnt == LAST;
endmodule

// File: rtl/logmap_cfg_sequencer.sv
// logmap_cfg_sequencer: AXI4-Lite master that writes the four logmapAXI registers from one
// start request, reads them back, and reports done plus the first error seen.
module logmap_cfg_sequencer
    import logmap_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDR  = 32'h0000_0000,
    parameter int          C_ADDR_WIDTH = 4,
    parameter int          C_TIMEOUT    = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic [127:0]            cfg_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code,
    output logic [1:0]              err_idx,
    output logic [C_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [31:0]             m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [31:0]             m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    state_t                  r_state, w_next;
    logic [127:0]            r_cfg;
    logic [1:0]              r_idx, r_err_code, r_err_idx, w_r_code, w_fail_code;
    logic                    r_aw_done, r_w_done;
    logic                    w_aw_ok, w_w_ok, w_b_err, w_last, w_expired, w_adv, w_enter_fin;
    logic [31:0]             w_word;
    logic [C_ADDR_WIDTH-1:0] w_addr;

    assign w_word      = r_cfg[{r_idx, 5'd0} +: 32];
    assign w_addr      = C_ADDR_WIDTH'(C_BASE_ADDR + 32'(REG_STRIDE) * {30'd0, r_idx});
    assign w_last      = r_idx == 2'(NUM_REGS - 1);
    assign w_aw_ok     = r_aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_w_ok      = r_w_done | (m_axi_wvalid & m_axi_wready);
    assign w_b_err     = m_axi_bresp != AXI_RESP_OKAY;
    assign w_r_code    = (m_axi_rresp != AXI_RESP_OKAY) ? ERR_RRESP :
                         (m_axi_rdata != w_word) ? ERR_DATA : ERR_NONE;
    // Anything that reaches FINISH without a response in hand is a timeout.
    assign w_fail_code = (r_state == ST_WR_RESP && m_axi_bvalid) ? (w_b_err ? ERR_BRESP : ERR_NONE) :
                         (r_state == ST_RD_RESP && m_axi_rvalid) ? w_r_code : ERR_DATA;
    assign w_adv       = (r_state == ST_WR_RESP && m_axi_bvalid && !w_b_err) ||
                         (r_state == ST_RD_RESP && m_axi_rvalid && w_r_code == ERR_NONE);
    assign w_enter_fin = w_next == ST_FINISH && r_state != ST_FINISH;

    logmap_watchdog #(.C_TIMEOUT(C_TIMEOUT)) u_wdog (
        .i_clk     (ACLK),
        .i_rst_n   (ARESETN),
        .i_clear   (w_next != r_state),
        .o_expired (w_expired)
    );

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = start ? ST_WR_REQ : ST_IDLE;
            ST_WR_REQ:  w_next = (w_aw_ok && w_w_ok) ? ST_WR_RESP : w_expired ? ST_FINISH : ST_WR_REQ;
            ST_WR_RESP: w_next = m_axi_bvalid ? (w_b_err ? ST_FINISH : w_last ? ST_RD_REQ : ST_WR_REQ) :
                                 w_expired ? ST_FINISH : ST_WR_RESP;
            ST_RD_REQ:  w_next = m_axi_arready ? ST_RD_RESP : w_expired ? ST_FINISH : ST_RD_REQ;
            ST_RD_RESP: w_next = m_axi_rvalid ? ((w_r_code != ERR_NONE || w_last) ? ST_FINISH : ST_RD_REQ) :
                                 w_expired ? ST_FINISH : ST_RD_RESP;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cfg      <= '0;
            r_idx      <= '0;
            r_err_code <= ERR_NONE;
            r_err_idx  <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_aw_done <= r_state == ST_WR_REQ && w_next == ST_WR_REQ && w_aw_ok;
            r_w_done  <= r_state == ST_WR_REQ && w_next == ST_WR_REQ && w_w_ok;
            if (r_state == ST_IDLE && start) begin
                r_cfg      <= cfg_data;
                r_idx      <= '0;
                r_err_code <= ERR_NONE;
                r_err_idx  <= '0;
            end else if (w_enter_fin) begin
                r_err_code <= w_fail_code;
                r_err_idx  <= (w_fail_code != ERR_NONE) ? r_idx : r_err_idx;
            end else if (w_adv) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    always_comb begin
        m_axi_awvalid = r_state == ST_WR_REQ && !r_aw_done;
        m_axi_wvalid  = r_state == ST_WR_REQ && !r_w_done;
        m_axi_bready  = r_state == ST_WR_RESP;
        m_axi_arvalid = r_state == ST_RD_REQ;
        m_axi_rready  = r_state == ST_RD_RESP;
        m_axi_awaddr  = m_axi_awvalid ? w_addr : '0;
        m_axi_wdata   = m_axi_wvalid ? w_word : '0;
        m_axi_wstrb   = m_axi_wvalid ? 4'hF : 4'h0;
        m_axi_araddr  = m_axi_arvalid ? w_addr : '0;
        busy          = r_state != ST_IDLE;
        done          = r_state == ST_FINISH;
    end

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign error        = r_err_code != ERR_NONE;
    assign err_code     = r_err_code;
    assign err_idx      = r_err_idx;
endmodule
